// File: rtl/decim_avg.sv
// decim_avg: decimating boxcar averager.
// Averages windows of 2^k accepted samples, where k is chosen at run time.
// Each window mean goes out through a one-entry valid/ready holding register.
// Optional feature macro: DECIM_MINMAX_EN adds per-window signed min/max
// outputs. When it is undefined, min_o and max_o are tied to zero and the
// port list is unchanged.

module decim_avg #(
   parameter int WIDTH    = 16,
   parameter int MAX_LOG2 = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic signed [WIDTH-1:0] data_i,
   input  logic                    enable_i,
   input  logic [4:0]              log2_n_i,
   input  logic                    clear_i,
   output logic signed [WIDTH-1:0] data_o,
   output logic                    valid_o,
   input  logic                    ready_i,
   output logic                    overrun_o,
   output logic signed [WIDTH-1:0] min_o,
   output logic signed [WIDTH-1:0] max_o
);

   localparam int         AW    = WIDTH + MAX_LOG2;  // accumulator cannot wrap at k = MAX_LOG2
   localparam int         CW    = MAX_LOG2 + 1;      // counter width, holds 2^MAX_LOG2 - 1
   localparam logic [4:0] MAX_K = 5'(MAX_LOG2);

   logic signed [AW-1:0]    acc_reg;
   logic [CW-1:0]           cnt_reg;
   logic [4:0]              k_reg;

   logic [4:0]              k_clamp;
   logic [4:0]              k_eff;
   logic                    accept;
   logic                    window_start;
   logic                    window_last;
   logic [CW-1:0]           last_cnt;
   logic signed [AW-1:0]    sample_ext;
   logic signed [AW-1:0]    sum_next;
   logic signed [WIDTH-1:0] mean_next;

   // Window bookkeeping. The k used for a window is the live input at its
   // first sample and the latched copy afterwards. A clear suppresses the
   // sample presented in the same cycle.
   always_comb begin
      k_clamp      = (log2_n_i > MAX_K) ? MAX_K : log2_n_i;
      window_start = (cnt_reg == '0);
      k_eff        = window_start ? k_clamp : k_reg;
      accept       = enable_i & ~clear_i;
      last_cnt     = (CW'(1) << k_eff) - CW'(1);
      window_last  = accept && (cnt_reg == last_cnt);
      sample_ext   = {{MAX_LOG2{data_i[WIDTH-1]}}, data_i};
      sum_next     = acc_reg + sample_ext;
      // An arithmetic shift floors toward -inf. The mean of in-range samples
      // always fits in WIDTH bits, so truncating loses nothing.
      mean_next    = WIDTH'(sum_next >>> k_eff);
   end

   // Accumulator, sample counter and latched window length.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         acc_reg <= '0;
         cnt_reg <= '0;
         k_reg   <= '0;
      end else if (clear_i) begin
         acc_reg <= '0;
         cnt_reg <= '0;
      end else if (accept) begin
         if (window_start) begin
            k_reg <= k_clamp;
         end
         if (window_last) begin
            acc_reg <= '0;
            cnt_reg <= '0;
         end else begin
            acc_reg <= sum_next;
            cnt_reg <= cnt_reg + CW'(1);
         end
      end
   end

   // Output holding register. A fresh result always wins. Overwriting an
   // unread result sets the sticky overrun flag.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data_o    <= '0;
         valid_o   <= 1'b0;
         overrun_o <= 1'b0;
      end else if (clear_i) begin
         valid_o   <= 1'b0;
         overrun_o <= 1'b0;
      end else if (window_last) begin
         data_o  <= mean_next;
         valid_o <= 1'b1;
         if (valid_o && !ready_i) begin
            overrun_o <= 1'b1;
         end
      end else if (valid_o && ready_i) begin
         valid_o <= 1'b0;
      end
   end

`ifdef DECIM_MINMAX_EN
   logic signed [WIDTH-1:0] min_trk_reg;
   logic signed [WIDTH-1:0] max_trk_reg;
   logic signed [WIDTH-1:0] win_min;
   logic signed [WIDTH-1:0] win_max;

   // Running extremes that include the current sample. The first sample of
   // a window seeds both trackers.
   always_comb begin
      win_min = data_i;
      win_max = data_i;
      if (!window_start) begin
         win_min = (data_i < min_trk_reg) ? data_i : min_trk_reg;
         win_max = (data_i > max_trk_reg) ? data_i : max_trk_reg;
      end
   end

   // Per-window min/max trackers. A clear discards the partial window.
   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         min_trk_reg <= '0;
         max_trk_reg <= '0;
      end else if (accept) begin
         min_trk_reg <= win_min;
         max_trk_reg <= win_max;
      end
   end

   // Min/max outputs load together with data_o. Like data_o, they keep their
   // value across a clear.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         min_o <= '0;
         max_o <= '0;
      end else if (!clear_i && window_last) begin
         min_o <= win_min;
         max_o <= win_max;
      end
   end
`else
   assign min_o = '0;
   assign max_o = '0;
`endif

endmodule

// File: tb/tb_decim_avg.sv
// Self-checking bench for decim_avg: directed scenarios plus random traffic.
// Expected outputs come from a queue-based window model.

module tb_decim_avg;

   logic                clk = 1'b0;
   logic                rst;
   logic                en;
   logic                clr;
   logic                rdy;
   logic signed [15:0]  din;
   logic [4:0]          kin;
   logic signed [15:0]  dout;
   logic signed [15:0]  mn;
   logic signed [15:0]  mx;
   logic                vld;
   logic                ovr;

   int checks = 0;
   int errors = 0;

   // Model state: samples of the open window plus expected register contents.
   int                  win_q[$];
   int                  m_k = 0;
   logic signed [15:0]  e_data = '0;
   logic signed [15:0]  e_min  = '0;
   logic signed [15:0]  e_max  = '0;
   logic                e_valid = 1'b0;
   logic                e_ovr   = 1'b0;
   bit                  cmp_on  = 1'b0;

   always #5 clk = ~clk;

   decim_avg #(.WIDTH(16), .MAX_LOG2(16)) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .data_i    (din),
      .enable_i  (en),
      .log2_n_i  (kin),
      .clear_i   (clr),
      .data_o    (dout),
      .valid_o   (vld),
      .ready_i   (rdy),
      .overrun_o (ovr),
      .min_o     (mn),
      .max_o     (mx)
   );

   task automatic chk(input string name, input logic signed [31:0] act,
                      input logic signed [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Per-cycle comparison of every DUT output against the model.
   always @(negedge clk) begin
      if (cmp_on) begin
         chk("valid",   vld,  e_valid);
         chk("data",    dout, e_data);
         chk("overrun", ovr,  e_ovr);
         chk("min",     mn,   e_min);
         chk("max",     mx,   e_max);
      end
   end

   // Drive one clock cycle and advance the model from the window rules.
   task automatic step(input bit r, input bit c, input bit e, input int d,
                       input int k, input bit rd);
      logic signed [15:0] nd;
      logic signed [15:0] nmin;
      logic signed [15:0] nmax;
      logic               nv;
      logic               no;
      bit                 newr;
      longint             sum;
      longint             n;
      longint             q;
      int                 lo;
      int                 hi;
      rst = r; clr = c; en = e; din = 16'(d); kin = 5'(k); rdy = rd;
      nd = e_data; nmin = e_min; nmax = e_max; nv = e_valid; no = e_ovr;
      newr = 1'b0; q = 0; lo = 0; hi = 0;
      if (r) begin
         win_q.delete();
         nd = '0; nmin = '0; nmax = '0; nv = 1'b0; no = 1'b0;
      end else if (c) begin
         win_q.delete();
         nv = 1'b0; no = 1'b0;
      end else begin
         if (e) begin
            if (win_q.size() == 0) m_k = (kin > 5'd16) ? 16 : int'(kin);
            win_q.push_back(int'(din));
            if (win_q.size() == (1 << m_k)) begin
               sum = 0;
               lo = win_q[0];
               hi = win_q[0];
               foreach (win_q[i]) begin
                  sum += win_q[i];
                  if (win_q[i] < lo) lo = win_q[i];
                  if (win_q[i] > hi) hi = win_q[i];
               end
               n = longint'(1) << m_k;
               q = sum / n;
               if (q * n != sum && sum < 0) q = q - 1;
               newr = 1'b1;
               win_q.delete();
            end
         end
         if (newr) begin
            if (nv && !rd) no = 1'b1;
            nd = 16'(q);
            nv = 1'b1;
`ifdef DECIM_MINMAX_EN
            nmin = 16'(lo);
            nmax = 16'(hi);
`endif
         end else if (nv && rd) begin
            nv = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      e_data = nd; e_min = nmin; e_max = nmax; e_valid = nv; e_ovr = no;
      cmp_on = 1'b1;
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) step(0, 0, 0, 0, 0, 1);
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; en = 1'b0; din = '0; kin = '0; rdy = 1'b0;
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      chk("reset_valid", vld, 0);
      chk("reset_data", dout, 0);
      chk("reset_overrun", ovr, 0);

      // Basic average, k=2: mean of 1..4 is 2.
      for (int i = 1; i <= 4; i++) step(0, 0, 1, i, 2, 1);
      chk("basic_valid", vld, 1);
      chk("basic_data", dout, 2);
      chk("model_basic", e_data, 2);
`ifdef DECIM_MINMAX_EN
      chk("basic_min", mn, 1);
      chk("basic_max", mx, 4);
`endif
      idle(1);
      chk("basic_pulse_end", vld, 0);

      // Negative rounding, k=1: (-3 + -2) / 2 floors to -3.
      step(0, 0, 1, -3, 1, 1);
      step(0, 0, 1, -2, 1, 1);
      chk("neg_round", dout, -3);
      chk("model_neg", e_data, -3);
      idle(1);

      // Back-pressure with k=0: the second result overwrites the first.
      step(0, 0, 1, 5, 0, 0);
      step(0, 0, 1, 7, 0, 0);
      chk("bp_data", dout, 7);
      chk("bp_valid", vld, 1);
      chk("bp_overrun", ovr, 1);
      step(0, 0, 0, 0, 0, 1);
      chk("bp_drain_valid", vld, 0);
      chk("bp_sticky", ovr, 1);
      step(0, 1, 0, 0, 0, 1);
      chk("bp_clear_ovr", ovr, 0);
      chk("bp_clear_keeps_data", dout, 7);

      // Mid-window k change: an 8-sample window, then a 2-sample window.
      step(0, 0, 1, 1, 3, 1);
      step(0, 0, 1, 2, 3, 1);
      for (int i = 3; i <= 7; i++) step(0, 0, 1, i, 1, 1);
      chk("kchg_not_yet", vld, 0);
      step(0, 0, 1, 8, 1, 1);
      chk("kchg_first", dout, 4);
      step(0, 0, 1, 10, 1, 1);
      step(0, 0, 1, 20, 1, 1);
      chk("kchg_second", dout, 15);
      chk("kchg_second_valid", vld, 1);

      // Pausing between samples holds the partial window.
      step(0, 0, 1, 4, 2, 1);
      step(0, 0, 1, 6, 2, 1);
      idle(5);
      step(0, 0, 1, 8, 2, 1);
      chk("pause_pending", vld, 0);
      step(0, 0, 1, 10, 2, 1);
      chk("pause_mean", dout, 7);

      // Reset mid-window, after which a fresh window starts.
      step(0, 0, 1, 100, 2, 1);
      step(0, 0, 1, 100, 2, 1);
      step(1, 0, 0, 0, 2, 1);
      chk("rst_mid_data", dout, 0);
      chk("rst_mid_valid", vld, 0);
      for (int i = 1; i <= 4; i++) step(0, 0, 1, 2 * i, 2, 1);
      chk("rst_fresh", dout, 5);

      // A clear discards the sample presented with it.
      step(0, 0, 1, 10, 1, 1);
      step(0, 1, 1, 1000, 1, 1);
      step(0, 0, 1, 20, 1, 1);
      chk("clr_discard_pending", vld, 0);
      step(0, 0, 1, 30, 1, 1);
      chk("clr_discard_mean", dout, 25);

      // Throughput with k=0 and ready held high.
      for (int i = 0; i < 10; i++) begin
         step(0, 0, 1, i * 3 - 7, 0, 1);
         chk("tput_valid", vld, 1);
         chk("tput_data", dout, i * 3 - 7);
      end
      idle(1);

      // Full scale with k clamped from 31 to 16.
      for (int i = 0; i < 65536; i++) step(0, 0, 1, -32768, 31, 1);
      chk("full_neg", dout, -32768);
      chk("full_neg_valid", vld, 1);
      idle(1);
      for (int i = 0; i < 4096; i++) step(0, 0, 1, 32767, 12, 1);
      chk("full_pos", dout, 32767);
      idle(1);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         int d;
         int k;
         d = int'($urandom_range(0, 65535)) - 32768;
         if ($urandom_range(0, 7) == 0) d = ($urandom_range(0, 1) == 0) ? -32768 : 32767;
         k = ($urandom_range(0, 19) == 0) ? int'($urandom_range(17, 31))
                                          : int'($urandom_range(0, 4));
         step($urandom_range(0, 199) == 0, $urandom_range(0, 49) == 0,
              $urandom_range(0, 3) != 0, d, k, $urandom_range(0, 1) == 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/decim_avg.md
# decim_avg

Decimating boxcar averager placed directly downstream of the low-pass filter stage. It consumes the filter's 16-bit signed output on every enabled clock and averages windows of 2^k samples, with k selectable at run time. Each window mean is presented on a valid/ready output with a one-entry holding register. Typical consumers are the DMA/readout path.

## Interface
- `WIDTH`, 16, sample width (signed, input and output)
- `MAX_LOG2`, 16, largest supported log2 window length; accumulator is `WIDTH+MAX_LOG2` bits signed
- `clk_i` in 1, single clock
- `rst_i` in 1, synchronous, active-high reset
- `data_i` in `WIDTH`, signed filtered sample
- `enable_i` in 1, sample qualifier; `data_i` is accepted on every cycle with `enable_i`=1
- `log2_n_i` in 5, window length exponent k; values above `MAX_LOG2` are clamped to `MAX_LOG2`
- `clear_i` in 1, synchronous flush
- `data_o` out `WIDTH`, signed window mean
- `valid_o` out 1, `data_o` holds an unconsumed result
- `ready_i` in 1, consumer accepts the result when `valid_o`&`ready_i`
- `overrun_o` out 1, sticky flag: an unconsumed result was overwritten
- `min_o` out `WIDTH`, window minimum (see Configuration)
- `max_o` out `WIDTH`, window maximum (see Configuration)

## Operation
- Reset (`rst_i`=1 at a clock edge) clears everything: accumulator, sample counter, `data_o`, `valid_o`, `overrun_o`, `min_o`, `max_o` all become 0. Reset has priority over all other inputs.
- Window start is defined as sample counter = 0. At the first accepted sample of a window, the clamped k is latched. Changes to `log2_n_i` mid-window take effect only at the next window.
- Each accepted sample does two things: the sign-extended `data_i` is added to the accumulator, and the counter is incremented.
- On the 2^k-th accepted sample:
  - result = (acc + `data_i`) >>> k, arithmetic shift, which floors toward −inf;
  - the result is truncated to `WIDTH` bits, which is lossless because the mean stays in range;
  - the accumulator and counter return to 0.
- k=0 degenerates to a registered pass-through of every accepted sample.
- `enable_i`=0 pauses the window; the partial sum and count are held.
- Output register behaviour:
  - A new result loads `data_o` and sets `valid_o`.
  - `valid_o`&`ready_i` with no new result: `valid_o` clears.
  - New result while `valid_o`=1 and `ready_i`=0: `data_o` is overwritten, `valid_o` stays 1, `overrun_o` is set.
  - New result while `valid_o`&`ready_i`: the old result counts as consumed, the new one loads, `valid_o` stays 1, no overrun.
- `clear_i`=1 has the following effects:
  - it discards the partial window (acc, count, min/max trackers reset);
  - it drops any pending result (`valid_o`→0) and clears `overrun_o`;
  - `data_o` keeps its last value;
  - a sample with `enable_i` in the same cycle is discarded.

## Timing
- Latency is 1 clock: `valid_o` and the new `data_o` appear on the edge following the cycle that accepted the last sample of the window.
- The block accepts one sample per clock; `data_i` is never back-pressured, because `ready_i` affects only the output register.
- `overrun_o` is registered and is set on the same edge that overwrites `data_o`.
- Throughput bound: with k=0 and `ready_i` held high, `valid_o` stays high continuously and a new value appears every cycle.

## Configuration
- Macro: `DECIM_MINMAX_EN`.
- Defined:
  - running signed min and max of the accepted samples are tracked per window;
  - `min_o`/`max_o` load on the same edge as `data_o` and follow the same overwrite/clear rules;
  - the trackers are initialised from the first sample of each window.
- Undefined:
  - no trackers are built;
  - `min_o` and `max_o` are tied to 0, so the port list is identical in both builds.

## Test plan
- Basic average: k=2, `ready_i`=1, samples 1,2,3,4 on consecutive cycles → `valid_o` pulses 1 cycle after sample 4 with `data_o`=2; with the macro, `min_o`=1 and `max_o`=4.
- Negative rounding: k=1, samples −3,−2 → `data_o`=−3.
- Back-pressure:
  - k=0, `ready_i`=0, samples 5 then 7 → `data_o`=7, `valid_o`=1, `overrun_o`=1;
  - then `ready_i`=1 for one cycle → `valid_o`=0 on the next edge, `overrun_o` stays 1;
  - then `clear_i` → `overrun_o`=0.
- Mid-window k change: k=3 at window start, switched to 1 after 2 samples → first result after 8 samples; the following window is 2 samples.
- Full-scale accumulation: k=16, 65536 samples of −32768 → `data_o`=−32768, no wrap. Repeat with +32767 → `data_o`=32767.
- Pause and reset:
  - k=2, 2 samples, `enable_i`=0 for 5 cycles, 2 more samples → one result, correct mean;
  - `rst_i` asserted mid-window → all outputs 0 next edge, and the next window starts fresh.
